sample_frame_ctrl: RTL and testbench



---
 rtl/sample_frame_ctrl.sv | 121 ++++++++++++
 tb/tb_sample_frame_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_frame_ctrl.sv
// Ping-pong frame controller: one single-port sample RAM shared by the sample writer and the frame reader.
// Optional decimation of the incoming stream is compiled in with SAMPLE_DECIM_EN.
module sample_frame_ctrl #(
    parameter int FRAME_LOG2 = 6,
    parameter int DECIM      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           sample_in,
    input  logic                  sample_valid,
    input  logic                  rd_req,
    input  logic [FRAME_LOG2-1:0] rd_idx,
    output logic                  rd_gnt,
    output logic [15:0]           rd_data,
    output logic                  rd_valid,
    input  logic                  frame_done,
    output logic                  frame_ready,
    output logic                  frame_avail,
    output logic                  overrun,
    output logic [7:0]            drop_cnt,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [FRAME_LOG2:0]   mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata
);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic                  wr_bank;
    logic                  rd_bank;
    logic [FRAME_LOG2-1:0] wr_ptr;
    logic                  accept;
    logic                  complete;
    logic                  swap;
    logic                  vld_p1;

`ifdef SAMPLE_DECIM_EN
    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    logic [DW-1:0] dec_cnt;

    // Every strobe advances the phase; only phase 0 reaches the memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_cnt <= '0;
        end else if (sample_valid) begin
            dec_cnt <= (dec_cnt == DW'(DECIM - 1)) ? '0 : dec_cnt + 1'b1;
        end
    end

    assign accept = sample_valid && (dec_cnt == '0);
`else
    // DECIM only matters with decimation compiled in.
    logic unused_decim;
    assign unused_decim = ^DECIM;
    assign accept       = sample_valid;
`endif

    assign complete = accept && (wr_ptr == '1);
    // A done coinciding with completion frees the read bank first, so the new frame swaps in.
    assign swap     = complete && (!frame_avail || frame_done);
    assign rd_gnt   = rd_req && frame_avail && !accept && !frame_done;
    assign rd_data  = rd_valid ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b1;
            wr_ptr      <= '0;
            frame_avail <= 1'b0;
            frame_ready <= 1'b0;
            overrun     <= 1'b0;
            drop_cnt    <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            vld_p1      <= 1'b0;
            rd_valid    <= 1'b0;
        end else begin
            // stage p1: registered memory command
            if (accept) begin
                mem_en    <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= {wr_bank, wr_ptr};
                mem_wdata <= sample_in;
                wr_ptr    <= wr_ptr + 1'b1;
            end else if (rd_gnt) begin
                mem_en   <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= {rd_bank, rd_idx};
            end else begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
            end
            vld_p1 <= rd_gnt;

            // stage p2: RAM output valid
            rd_valid <= vld_p1;

            frame_ready <= swap;
            if (swap) begin
                wr_bank     <= ~wr_bank;
                rd_bank     <= wr_bank;
                frame_avail <= 1'b1;
            end else begin
                if (frame_done) begin
                    frame_avail <= 1'b0;
                end
                // Reader still owns its bank: the finished write bank is simply refilled.
                if (complete) begin
                    overrun  <= 1'b1;
                    drop_cnt <= sat_inc8(drop_cnt);
                end
            end
        end
    end

endmodule

// File: tb/tb_sample_frame_ctrl.sv
// Self-checking bench for sample_frame_ctrl with FRAME_LOG2=2: vector table, hand sequences and a memory-command scoreboard.
`timescale 1ns/1ps
module tb_sample_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        rd_req;
    logic [1:0]  rd_idx;
    logic        rd_gnt;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        frame_done;
    logic        frame_ready;
    logic        frame_avail;
    logic        overrun;
    logic [7:0]  drop_cnt;
    logic        mem_en;
    logic        mem_we;
    logic [2:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    always #5 clk = ~clk;

    sample_frame_ctrl #(.FRAME_LOG2(2), .DECIM(4)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_gnt(rd_gnt), .rd_data(rd_data),
        .rd_valid(rd_valid), .frame_done(frame_done), .frame_ready(frame_ready),
        .frame_avail(frame_avail), .overrun(overrun), .drop_cnt(drop_cnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Behavioural single-port RAM, one cycle read latency.
    logic [15:0] ram [0:7];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    typedef struct {
        bit          we;
        logic [2:0]  addr;
        logic [15:0] data;
    } cmd_t;

    typedef struct {
        bit          sv;
        logic [15:0] din;
        bit          rq;
        logic [1:0]  ridx;
        bit          fd;
        bit          e_gnt;
        bit          e_rdy;
        bit          e_av;
        bit          e_ovr;
        logic [7:0]  e_drop;
        logic [2:0]  e_addr;
        logic [15:0] e_rdat;
    } vec_t;

    cmd_t        cmd_q[$];
    logic [15:0] rdat_q[$];
    vec_t        tbl[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          rdy_cnt = 0;
    int          rdy_base;

    function automatic cmd_t mk_cmd(input bit we, input logic [2:0] a, input logic [15:0] d);
        cmd_t c;
        c.we = we; c.addr = a; c.data = d;
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input bit sv, input logic [15:0] din, input bit rq, input logic [1:0] ridx,
                       input bit fd, input bit eg, input bit er, input bit ea, input bit eo,
                       input logic [7:0] ed, input logic [2:0] eaddr, input logic [15:0] erd);
        vec_t v;
        v.sv = sv; v.din = din; v.rq = rq; v.ridx = ridx; v.fd = fd;
        v.e_gnt = eg; v.e_rdy = er; v.e_av = ea; v.e_ovr = eo; v.e_drop = ed;
        v.e_addr = eaddr; v.e_rdat = erd;
        tbl.push_back(v);
    endtask

    task automatic step(input bit sv, input logic [15:0] din, input bit rq, input logic [1:0] ridx, input bit fd);
        @(posedge clk);
        #1;
        sample_valid = sv; sample_in = din; rd_req = rq; rd_idx = ridx; frame_done = fd;
    endtask

    task automatic send(input logic [15:0] din, input logic [2:0] addr);
        step(1'b1, din, 1'b0, 2'd0, 1'b0);
        cmd_q.push_back(mk_cmd(1'b1, addr, din));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"}, rd_gnt, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_frame_ready"}, frame_ready, 0);
        chk({tag, "_frame_avail"}, frame_avail, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_drop_cnt"}, drop_cnt, 0);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    task automatic monitor();
        cmd_t        c;
        logic [15:0] d;
        forever begin
            @(negedge clk);
            if (frame_ready) rdy_cnt++;
            if (mem_en) begin
                if (cmd_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_cmd: got we=%0b addr=%0h, expected no command", mem_we, mem_addr);
                end else begin
                    c = cmd_q.pop_front();
                    chk("cmd_we", mem_we, c.we);
                    chk("cmd_addr", mem_addr, c.addr);
                    if (c.we) chk("cmd_wdata", mem_wdata, c.data);
                end
            end
            if (rd_valid) begin
                if (rdat_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_rd_valid: got data %0h, expected rd_valid=0", rd_data);
                end else begin
                    d = rdat_q.pop_front();
                    chk("rd_data", rd_data, d);
                end
            end else begin
                chk("rd_data_idle", rd_data, 0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sample_valid = 1'b0; sample_in = '0; rd_req = 1'b0; rd_idx = '0; frame_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        fork monitor(); join_none
        @(posedge clk);
        #1 rst = 1'b0;

`ifndef SAMPLE_DECIM_EN
        // sv din rq idx fd | gnt rdy avail ovr drop addr rdata
        add(1,'h11,0,0,0, 0,0,0,0,0, 0,0);
        add(0,0,0,0,0,    0,0,0,0,0, 0,0);
        add(0,0,0,0,0,    0,0,0,0,0, 0,0);
        add(1,'h12,0,0,0, 0,0,0,0,0, 1,0);
        add(0,0,0,0,0,    0,0,0,0,0, 0,0);
        add(0,0,0,0,0,    0,0,0,0,0, 0,0);
        add(1,'h13,0,0,0, 0,0,0,0,0, 2,0);
        add(0,0,0,0,0,    0,0,0,0,0, 0,0);
        add(0,0,0,0,0,    0,0,0,0,0, 0,0);
        add(1,'h14,0,0,0, 0,0,0,0,0, 3,0);
        add(0,0,0,0,0,    0,1,1,0,0, 0,0);
        add(0,0,0,0,0,    0,0,1,0,0, 0,0);
        add(0,0,1,0,0,    1,0,1,0,0, 0,'h11);
        add(0,0,1,1,0,    1,0,1,0,0, 1,'h12);
        add(0,0,1,2,0,    1,0,1,0,0, 2,'h13);
        add(0,0,1,3,0,    1,0,1,0,0, 3,'h14);
        add(0,0,0,0,0,    0,0,1,0,0, 0,0);
        add(1,'h21,1,1,0, 0,0,1,0,0, 4,0);
        add(1,'h22,1,1,0, 0,0,1,0,0, 5,0);
        add(1,'h23,1,1,0, 0,0,1,0,0, 6,0);
        add(0,0,1,1,0,    1,0,1,0,0, 1,'h12);
        add(0,0,0,0,1,    0,0,1,0,0, 0,0);
        add(1,'h24,0,0,0, 0,0,0,0,0, 7,0);
        add(0,0,0,0,0,    0,1,1,0,0, 0,0);
        add(1,'h31,0,0,0, 0,0,1,0,0, 0,0);
        add(1,'h32,0,0,0, 0,0,1,0,0, 1,0);
        add(1,'h33,0,0,0, 0,0,1,0,0, 2,0);
        add(1,'h34,0,0,0, 0,0,1,0,0, 3,0);
        add(0,0,0,0,0,    0,0,1,1,1, 0,0);
        add(0,0,1,0,0,    1,0,1,1,1, 4,'h21);
        add(0,0,1,3,0,    1,0,1,1,1, 7,'h24);
        add(0,0,1,0,1,    0,0,1,1,1, 0,0);
        add(0,0,1,0,0,    0,0,0,1,1, 0,0);
        add(0,0,0,0,0,    0,0,0,1,1, 0,0);

        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].sv, tbl[k].din, tbl[k].rq, tbl[k].ridx, tbl[k].fd);
            if (tbl[k].sv) cmd_q.push_back(mk_cmd(1'b1, tbl[k].e_addr, tbl[k].din));
            if (tbl[k].e_gnt) begin
                cmd_q.push_back(mk_cmd(1'b0, tbl[k].e_addr, 16'h0));
                rdat_q.push_back(tbl[k].e_rdat);
            end
            @(negedge clk);
            chk($sformatf("v%0d_gnt", k), rd_gnt, tbl[k].e_gnt);
            chk($sformatf("v%0d_frame_ready", k), frame_ready, tbl[k].e_rdy);
            chk($sformatf("v%0d_frame_avail", k), frame_avail, tbl[k].e_av);
            chk($sformatf("v%0d_overrun", k), overrun, tbl[k].e_ovr);
            chk($sformatf("v%0d_drop_cnt", k), drop_cnt, tbl[k].e_drop);
        end

        // Read in flight when reset hits: its data must never surface.
        for (int i = 0; i < 4; i++) send(16'h41 + 16'(i), 3'(i));
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("refill_frame_ready", frame_ready, 1);
        chk("refill_frame_avail", frame_avail, 1);
        step(0, 0, 1, 2, 0);
        cmd_q.push_back(mk_cmd(1'b0, 3'd2, 16'h0));
        @(negedge clk);
        chk("inflight_gnt", rd_gnt, 1);
        @(posedge clk);
        #1 rst = 1'b1; rd_req = 1'b0;
        @(negedge clk);
        chk("inflight_rd_valid_n1", rd_valid, 0);
        @(negedge clk);
        chk("inflight_rd_valid_n2", rd_valid, 0);
        check_reset_outputs("rereset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Done coincident with completion of the next frame.
        for (int i = 0; i < 4; i++) send(16'h51 + 16'(i), 3'(i));
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("coinc_first_ready", frame_ready, 1);
        for (int i = 0; i < 3; i++) send(16'h61 + 16'(i), 3'(4 + i));
        step(1, 16'h64, 0, 0, 1);
        cmd_q.push_back(mk_cmd(1'b1, 3'd7, 16'h64));
        @(negedge clk);
        chk("coinc_gnt_blocked", rd_gnt, 0);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("coinc_frame_ready", frame_ready, 1);
        chk("coinc_frame_avail", frame_avail, 1);
        chk("coinc_overrun", overrun, 0);
        chk("coinc_drop_cnt", drop_cnt, 0);
        step(0, 0, 1, 0, 0);
        cmd_q.push_back(mk_cmd(1'b0, 3'd4, 16'h0));
        rdat_q.push_back(16'h61);
        @(negedge clk);
        chk("coinc_read_gnt", rd_gnt, 1);

        // Reader never releases: every completion is dropped until the counter saturates.
        rdy_base = rdy_cnt;
        for (int f = 0; f < 260; f++) begin
            for (int i = 0; i < 4; i++) begin
                send(16'(f * 4 + i), 3'(i));
                if (f == 1 && i == 0) begin
                    @(negedge clk);
                    chk("sat_first_drop", drop_cnt, 1);
                end
            end
        end
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("sat_drop_cnt", drop_cnt, 255);
        chk("sat_overrun", overrun, 1);
        chk("sat_frame_avail", frame_avail, 1);
        chk("sat_no_ready", rdy_cnt - rdy_base, 0);
        step(0, 0, 1, 1, 0);
        cmd_q.push_back(mk_cmd(1'b0, 3'd5, 16'h0));
        rdat_q.push_back(16'h62);
        @(negedge clk);
        chk("sat_read_gnt", rd_gnt, 1);
`else
        rdy_base = rdy_cnt;
        for (int i = 0; i < 16; i++) begin
            step(1, 16'(i), 0, 0, 0);
            if (i % 4 == 0) cmd_q.push_back(mk_cmd(1'b1, 3'(i / 4), 16'(i)));
        end
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("decim_frame_avail", frame_avail, 1);
        step(0, 0, 1, 2, 0);
        cmd_q.push_back(mk_cmd(1'b0, 3'd2, 16'h0));
        rdat_q.push_back(16'd8);
        @(negedge clk);
        chk("decim_read_gnt", rd_gnt, 1);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("decim_ready_pulses", rdy_cnt - rdy_base, 1);
`endif

        step(0, 0, 0, 0, 0);
        repeat (4) @(negedge clk);
        chk("cmd_queue_drained", cmd_q.size(), 0);
        chk("rdat_queue_drained", rdat_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
